// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the FP divide/sqrt issue queue.
package fpdiv_pkg;

  localparam int DST_W = 4;

  localparam logic [2:0] FMT_SINGLE = 3'b000;
  localparam logic [2:0] FMT_DOUBLE = 3'b001;
  localparam logic [2:0] FMT_QUAD   = 3'b100;

  typedef struct packed {
    logic             cmd;
    logic [2:0]       sa;
    logic [2:0]       sb;
    logic [127:0]     a;
    logic [127:0]     b;
    logic [DST_W-1:0] dst;
  } fpdiv_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAITBUSY,
    WAITDONE
  } iq_state_t;

endpackage

// File: rtl/fpdiv_req_fifo.sv
// In-order request storage with extended-pointer full/empty detection and flush.
module fpdiv_req_fifo
  import fpdiv_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fpdiv_req_t               wdata_i,
  output fpdiv_req_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push;
  fpdiv_req_t  mem_q [Depth];

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A push coinciding with flush is discarded along with the queued entries.
  assign do_push = push_i && !full_o && !flush_i;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (flush_i)                   rptr_d = wptr_q;
    else if (pop_i && !empty_o)    rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fpdiv_issue_queue.sv
// Request buffer and one-at-a-time issue sequencer in front of the 128-bit FP divide/sqrt unit.
module fpdiv_issue_queue
  import fpdiv_pkg::*;
#(
  parameter int DSTWidth = DST_W,
  parameter int Depth    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ACT,
  input  logic                     CMD,
  input  logic [2:0]               SA,
  input  logic [2:0]               SB,
  input  logic [127:0]             A,
  input  logic [127:0]             B,
  input  logic [DSTWidth-1:0]      DSTi,
  input  logic                     FLUSH,
  output logic                     NEXT,
  output logic                     DACT,
  output logic                     DCMD,
  output logic [2:0]               DSA,
  output logic [2:0]               DSB,
  output logic [127:0]             DA,
  output logic [127:0]             DB,
  output logic [DSTWidth-1:0]      DDST,
  input  logic                     DNEXT,
  input  logic                     DRDY,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Busy
);

  iq_state_t  state_q, state_d;
  fpdiv_req_t dreq_q, dreq_d;
  logic       busy_q, busy_d;

  fpdiv_req_t push_req, head_req;
  logic       full, empty, pop, can_issue;

  assign push_req = {CMD, SA, SB, A, B, DSTi};

  fpdiv_req_fifo #(.Depth(Depth)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (ACT),
    .pop_i   (pop),
    .flush_i (FLUSH),
    .wdata_i (push_req),
    .rdata_o (head_req),
    .full_o  (full),
    .empty_o (empty),
    .count_o (Count)
  );

  assign NEXT      = !full;
  assign can_issue = !empty && DNEXT && !FLUSH;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy_d  = 1'b1;
        state_d = WAITBUSY;
      end
      WAITBUSY: begin
        if (DRDY) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!DNEXT) begin
          state_d = WAITDONE;
        end
      end
      WAITDONE: begin
        // Back-to-back issue is allowed on the DRDY cycle when the divider is already idle again.
        if (DRDY) begin
          busy_d = 1'b0;
          if (can_issue) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    dreq_d = pop ? head_req : dreq_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      dreq_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      dreq_q  <= dreq_d;
    end
  end

  // Busy rises the cycle after the strobe, so DACT and Busy are never high together.
  assign DACT = (state_q == ISSUE);
  assign Busy = busy_q;
  assign DCMD = dreq_q.cmd;
  assign DSA  = dreq_q.sa;
  assign DSB  = dreq_q.sb;
  assign DA   = dreq_q.a;
  assign DB   = dreq_q.b;
  assign DDST = dreq_q.dst;

endmodule
